// File: rtl/dump_window_ctrl.sv
// Capture-window controller: arm, wait for a trigger edge, wait a programmable
// delay, then emit a decimated train of single-cycle dump enables.
module dump_window_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] decim,
  input  logic [CNT_WIDTH-1:0] n_samples,
  output logic                 dump_en,
  output logic [CNT_WIDTH-1:0] sample_idx,
  output logic                 armed,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] dly;
    logic [CNT_WIDTH-1:0] dec;
    logic [CNT_WIDTH-1:0] nsmp;
  } cfg_t;

  state_t               state_q, state_d;
  cfg_t                 cfg_q, cfg_d;
  logic                 trig_q;
  logic                 trig_edge_c;
  logic [CNT_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0] idx_d;
  logic                 dump_d;

  assign trig_edge_c = trig & ~trig_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counters and next output values
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    dly_cnt_d = dly_cnt_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = sample_idx;
    dump_d    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            cfg_d.dly  = delay;
            cfg_d.dec  = decim;
            cfg_d.nsmp = n_samples;
            idx_d      = '0;
            state_d    = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_edge_c) begin
            if (cfg_q.nsmp == '0) begin
              state_d = S_DONE;
            end else if (cfg_q.dly == '0) begin
              state_d = S_CAPTURE;
              dump_d  = 1'b1;
            end else begin
              state_d   = S_DELAY;
              dly_cnt_d = cfg_q.dly - CNT_WIDTH'(1);
            end
          end
        end
        S_DELAY: begin
          if (dly_cnt_q == '0) begin
            state_d = S_CAPTURE;
            dump_d  = 1'b1;
          end else begin
            dly_cnt_d = dly_cnt_q - CNT_WIDTH'(1);
          end
        end
        S_CAPTURE: begin
          // Pulse cycle: advance index, then finish, pulse again, or start the gap
          if (dump_en) begin
            idx_d = sample_idx + CNT_WIDTH'(1);
            if (sample_idx == cfg_q.nsmp - CNT_WIDTH'(1)) begin
              state_d = S_DONE;
            end else if (cfg_q.dec == '0) begin
              dump_d = 1'b1;
            end else begin
              gap_cnt_d = cfg_q.dec - CNT_WIDTH'(1);
            end
          end else if (gap_cnt_q == '0) begin
            dump_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      trig_q     <= 1'b0;
      dly_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sample_idx <= '0;
      dump_en    <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      trig_q     <= trig;
      dly_cnt_q  <= dly_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sample_idx <= idx_d;
      dump_en    <= dump_d;
      armed      <= (state_d == S_ARMED);
      busy       <= (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_CAPTURE);
      done       <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Bench for dump_window_ctrl: window-schedule reference model checked every
// cycle, plus directed scenarios with hand-computed pulse positions.
module tb_dump_window_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         arm = 1'b0;
  logic         abort = 1'b0;
  logic         trig = 1'b0;
  logic [W-1:0] delay = '0;
  logic [W-1:0] decim = '0;
  logic [W-1:0] n_samples = '0;
  logic         dump_en;
  logic [W-1:0] sample_idx;
  logic         armed;
  logic         busy;
  logic         done;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;

  always #5 clk = ~clk;

  dump_window_ctrl #(.CNT_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .abort      (abort),
    .trig       (trig),
    .delay      (delay),
    .decim      (decim),
    .n_samples  (n_samples),
    .dump_en    (dump_en),
    .sample_idx (sample_idx),
    .armed      (armed),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 armed, 2 window running, 3 done.
  // A running window is described only by its edge cycle and configuration;
  // outputs for any cycle follow from arithmetic on that schedule.
  int     m_mode = 0;
  bit     m_trq = 1'b0;
  bit     m_valid = 1'b0;
  longint m_d = 0, m_g = 0, m_n = 0, m_t = 0;
  longint e_idx = 0;
  bit     e_dump = 1'b0, e_armed = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge clk) begin : model
    longint p, c, first, fin, rel, per;
    bit     edge_s;
    p = cyc;
    cyc = cyc + 1;
    c = cyc;
    if (rst) begin
      m_mode = 0; m_d = 0; m_g = 0; m_n = 0; m_trq = 1'b0; e_idx = 0;
      m_valid = 1'b1;
    end else begin
      edge_s = trig && !m_trq;
      if (abort) begin
        m_mode = 0;
      end else if (arm && (m_mode == 0 || m_mode == 3)) begin
        m_d = longint'(delay); m_g = longint'(decim); m_n = longint'(n_samples);
        e_idx = 0;
        m_mode = 1;
      end else if (m_mode == 1 && edge_s) begin
        m_t = p;
        m_mode = 2;
      end
      m_trq = trig;
    end
    e_dump = 1'b0;
    if (m_mode == 2) begin
      per   = m_g + 1;
      first = m_t + 1 + m_d;
      fin   = (m_n == 0) ? m_t + 1 : first + (m_n - 1) * per + 1;
      if (c >= fin) begin
        m_mode = 3;
      end else if (c < first) begin
        e_idx = 0;
      end else begin
        rel    = c - first;
        e_dump = (rel % per == 0);
        e_idx  = rel / per + ((rel % per != 0) ? 1 : 0);
      end
    end
    if (m_mode == 3) e_idx = m_n;
    e_armed = (m_mode == 1);
    e_busy  = (m_mode == 1) || (m_mode == 2);
    e_done  = (m_mode == 3);
  end

  // Compare DUT against model every cycle once reset has been applied
  always @(negedge clk) begin
    if (m_valid) begin
      chk("dump_en",    64'(dump_en),    64'(e_dump));
      chk("sample_idx", 64'(sample_idx), e_idx);
      chk("armed",      64'(armed),      64'(e_armed));
      chk("busy",       64'(busy),       64'(e_busy));
      chk("done",       64'(done),       64'(e_done));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic arm_cfg(input int d, input int g, input int n);
    arm = 1'b1;
    delay = W'(d);
    decim = W'(g);
    n_samples = W'(n);
    tick();
    arm = 1'b0;
    chk("arm_armed", 64'(armed), 64'(1));
    chk("arm_busy",  64'(busy),  64'(1));
  endtask

  initial begin
    tick(); tick();
    chk("rst_dump", 64'(dump_en), 64'(0));
    chk("rst_idx",  64'(sample_idx), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    tick();

    // Basic window: delay 3, decim 0, 4 samples
    arm_cfg(3, 0, 4);
    tick(); tick();
    trig = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 1) trig = 1'b0;
      chk("basic_dump", 64'(dump_en), 64'((j >= 4) && (j <= 7)));
      if (j >= 4 && j <= 7) chk("basic_idx", 64'(sample_idx), 64'(j - 4));
    end
    chk("basic_done", 64'(done), 64'(1));
    chk("basic_busy", 64'(busy), 64'(0));
    chk("basic_idx_done", 64'(sample_idx), 64'(4));

    // Re-arm in the first DONE cycle: delay 1, decim 1, 2 samples
    arm_cfg(1, 1, 2);
    tick();
    trig = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) trig = 1'b0;
      chk("rearm_dump", 64'(dump_en), 64'((j == 2) || (j == 4)));
      if (j == 5) chk("rearm_done", 64'(done), 64'(1));
    end

    // Decimation: delay 0, decim 2, 3 samples
    arm_cfg(0, 2, 3);
    tick();
    trig = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 1) trig = 1'b0;
      chk("decim_dump", 64'(dump_en), 64'((j == 1) || (j == 4) || (j == 7)));
    end
    chk("decim_done", 64'(done), 64'(1));

    // Trigger high before and through arm needs a fresh rising edge
    trig = 1'b1;
    tick(); tick();
    arm_cfg(2, 0, 2);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("held_armed", 64'(armed), 64'(1));
      chk("held_dump",  64'(dump_en), 64'(0));
    end
    trig = 1'b0;
    tick();
    trig = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 1) trig = 1'b0;
      chk("fresh_dump", 64'(dump_en), 64'((j == 3) || (j == 4)));
    end
    chk("fresh_done", 64'(done), 64'(1));

    // Edge and arm during CAPTURE are ignored
    arm_cfg(0, 1, 5);
    tick();
    trig = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("cap_dump", 64'(dump_en), 64'((j % 2 == 1) && (j <= 9)));
      if (j == 1) trig = 1'b0;
      if (j == 2) begin
        trig = 1'b1; arm = 1'b1; delay = W'(7); decim = W'(0); n_samples = W'(9);
      end
      if (j == 3) begin
        trig = 1'b0; arm = 1'b0;
      end
    end
    chk("cap_done", 64'(done), 64'(1));
    chk("cap_idx",  64'(sample_idx), 64'(5));

    // Zero samples with a long delay: done right after the edge
    arm_cfg(100, 0, 0);
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_dump", 64'(dump_en), 64'(0));
    chk("zero_busy", 64'(busy), 64'(0));

    // Abort after pulse 1 of 5
    arm_cfg(0, 1, 5);
    tick();
    trig = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 1) trig = 1'b0;
      chk("abort_dump", 64'(dump_en), 64'((j == 1) || (j == 3)));
      if (j == 3) abort = 1'b1;
      if (j == 4) begin
        abort = 1'b0;
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
      end
    end

    // Reset during DELAY
    arm_cfg(10, 0, 3);
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstd_busy", 64'(busy), 64'(0));
    chk("rstd_idx",  64'(sample_idx), 64'(0));
    chk("rstd_dump", 64'(dump_en), 64'(0));
    for (int j = 0; j < 12; j++) tick();
    chk("rstd_quiet", 64'(dump_en), 64'(0));

    // Abort and arm together from DONE
    arm_cfg(0, 0, 1);
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("ab_pulse", 64'(dump_en), 64'(1));
    tick();
    chk("ab_indone", 64'(done), 64'(1));
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    chk("ab_armed", 64'(armed), 64'(0));
    chk("ab_done",  64'(done), 64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      abort = ($urandom_range(0, 79) == 0);
      arm   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) trig = ~trig;
      delay     = W'($urandom_range(0, 6));
      decim     = W'($urandom_range(0, 3));
      n_samples = W'($urandom_range(0, 6));
      tick();
    end
    rst = 1'b0; abort = 1'b0; arm = 1'b0; trig = 1'b0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dump_window_ctrl.md
# dump_window_ctrl

Capture-window controller that sequences the real-valued file dumpers in the simulation harness. After being armed it waits for a trigger edge, then a programmable delay, then emits a decimated train of single-cycle dump enables for a fixed sample count. Each enable makes a downstream dumper write one line. `dump_en` is intended to drive the dumpers' reset as its inverse, or to gate it. The block is synthesizable, so the same sequencing runs in emulation builds.

## Interface
- `CNT_WIDTH`, 32, width of the delay, decimation, sample-count and index fields.
- `clk`  input  1  clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset; priority over every other input.
- `arm`  input  1  single-cycle request to latch configuration and wait for trigger.
- `abort`  input  1  return to IDLE from any state; priority over `arm`.
- `trig`  input  1  trigger level; a rising edge starts the window.
- `delay`  input  CNT_WIDTH  cycles between trigger detection and first sample; latched on accepted `arm`.
- `decim`  input  CNT_WIDTH  idle cycles between samples (0 = every cycle); latched on accepted `arm`.
- `n_samples`  input  CNT_WIDTH  number of dump enables per window; latched on accepted `arm`.
- `dump_en`  output  1  registered; high for exactly one cycle per sample.
- `sample_idx`  output  CNT_WIDTH  registered; index of the current sample, valid while `dump_en`=1.
- `armed`  output  1  registered; high in ARMED.
- `busy`  output  1  registered; high in ARMED, DELAY or CAPTURE.
- `done`  output  1  registered; high in DONE.

## Operation
- States: IDLE, ARMED, DELAY, CAPTURE, DONE. Reset state is IDLE.
- Reset values: `dump_en`=0, `sample_idx`=0, `armed`=0, `busy`=0, `done`=0. All latched configuration is 0 and `trig_q` is 0.
- Edge detect: `trig_q` registers `trig` every cycle, including in IDLE. An edge is `trig & ~trig_q`.
- `arm` is accepted only in IDLE or DONE. An accepted `arm` latches `delay`, `decim` and `n_samples`, clears `sample_idx`, and moves the block to ARMED. In any other state `arm` is ignored.
- In ARMED, on an edge:
  - if the latched `n_samples`=0, go to DONE;
  - else if the latched `delay`=0, go to CAPTURE;
  - else go to DELAY and load the delay counter with `delay`-1.
- DELAY: the counter decrements each cycle. When the counter equals 0, go to CAPTURE.
- CAPTURE:
  - `dump_en`=1 on the first CAPTURE cycle.
  - After each pulse, `dump_en` stays low for `decim` cycles, then pulses again.
  - `sample_idx` holds k during the k-th pulse, counting from 0, and increments the cycle after each pulse.
  - The cycle after pulse number `n_samples`-1, go to DONE.
- DONE: `done` stays high until an accepted `arm`, `abort` or `rst`. `sample_idx` holds `n_samples`.
- Trigger edges outside ARMED are ignored, including an edge in the same cycle as the accepted `arm`. If `trig` is already high when the block is armed, a fresh low-to-high transition is required.
- `abort` in any state: next cycle the block is in IDLE with `dump_en`=0. Status outputs return to reset values. `sample_idx` is not cleared.
- Arithmetic: the counters are unsigned CNT_WIDTH-bit and never wrap, because the state machine exits before overflow. `n_samples`=2^CNT_WIDTH-1 is legal.

## Timing
- Accepted `arm` in cycle t: `armed`=1 and `busy`=1 in cycle t+1.
- Edge detected in cycle t with `delay`=D and `n_samples`>0: the first `dump_en` is in cycle t+1+D.
- Pulse k, counting from 0, occurs in cycle t+1+D+k·(`decim`+1).
- Last pulse in cycle p: `done`=1 and `busy`=0 from cycle p+1.
- `n_samples`=0: `done`=1 in cycle t+1 regardless of `delay`, and no pulse is ever emitted.
- `rst` or `abort` in cycle t: all flags low and no `dump_en` from cycle t+1.
- A window can be re-armed back-to-back: `arm` in the first DONE cycle gives ARMED in the next cycle.

## Test plan
- Basic window:
  - Stimulus: reset, arm with delay=3, decim=0, n_samples=4, edge detected in cycle 10.
  - Required: `dump_en` high in cycles 14–17 with `sample_idx` 0,1,2,3; `done`=1 from cycle 18.
- Decimation:
  - Stimulus: delay=0, decim=2, n_samples=3, edge detected in cycle 5.
  - Required: pulses in cycles 6, 9, 12 only; `done` from cycle 13.
- Trigger qualification:
  - Stimulus: `trig` held high before and through `arm`.
  - Required: no pulses; the block stays ARMED until `trig` goes 0 then 1.
  - Stimulus: an edge while IDLE or during CAPTURE.
  - Required: ignored.
- Zero samples and ignored arm:
  - Stimulus: n_samples=0, delay=100.
  - Required: `done` one cycle after the edge, no `dump_en`.
  - Stimulus: `arm` pulsed during CAPTURE.
  - Required: latched configuration unchanged; the window completes as originally configured.
- Abort and reset mid-capture:
  - Stimulus: `abort` after pulse 1 of 5.
  - Required: IDLE next cycle, no further pulses, `done`=0.
  - Stimulus: `rst` during DELAY.
  - Required: all outputs at reset values next cycle.
  - Stimulus: `abort` and `arm` in the same cycle from DONE.
  - Required: IDLE.
- Re-arm:
  - Stimulus: arm in the first DONE cycle with new delay=1, decim=1, n_samples=2, then an edge.
  - Required: new configuration used; pulses at edge+2 and edge+4.
